// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the default geometry (DEPTH/AW/DW), the access-counter width, the
// two-state controller encoding and a saturating-increment helper.
package dmem_pkg;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int CNT_W = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
// One synchronous write port and one asynchronous (combinational) read port.
// The array has no reset: contents change only through the write port.
// Ports:
//   clk    - clock, write happens on its rising edge
//   we     - write enable
//   waddr  - write word address
//   wdata  - write data
//   raddr  - read word address
//   rdata  - read data, combinational from raddr
module dmem_array #(
  parameter int AW = dmem_pkg::AW,
  parameter int DW = dmem_pkg::DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(2**AW)-1];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-cycle data memory seen by a simple core.
// After reset the array is zero-swept one word per edge (CLEAR), then the
// block honours reads (zero latency) and writes (one edge) in READY.
// Ports:
//   clk, rst_n      - clock and synchronous active-low reset
//   CEN, WEN, OEN   - access enable, write strobe, output enable (active-high)
//   A, D            - word address and write data
//   Q               - read data, 0 unless a read is being honoured
//   ready           - high while accesses are honoured
//   err             - sticky write+read conflict flag
//   rd_cnt, wr_cnt  - saturating counts of accepted reads and writes
module data_mem_responder #(
  parameter int DEPTH          = dmem_pkg::DEPTH,
  parameter int AW             = dmem_pkg::AW,
  parameter int DW             = dmem_pkg::DW,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       CEN,
  input  logic                       WEN,
  input  logic                       OEN,
  input  logic [AW-1:0]              A,
  input  logic [DW-1:0]              D,
  output logic [DW-1:0]              Q,
  output logic                       ready,
  output logic                       err,
  output logic [dmem_pkg::CNT_W-1:0] rd_cnt,
  output logic [dmem_pkg::CNT_W-1:0] wr_cnt
);

  import dmem_pkg::*;

  // Without the sweep the controller comes out of reset already in READY;
  // ready still stays low until the first edge with rst_n released.
  localparam dmem_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  dmem_state_e       state_r;
  dmem_state_e       state_nxt_s;
  logic [AW-1:0]     clr_ptr_r;
  logic [AW-1:0]     clr_ptr_nxt_s;
  logic              ready_r;
  logic              err_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic [CNT_W-1:0]  wr_cnt_r;

  logic              rd_s;
  logic              wr_s;
  logic              conf_s;
  logic              arr_we_s;
  logic [AW-1:0]     arr_addr_s;
  logic [DW-1:0]     arr_wdata_s;
  logic [DW-1:0]     arr_rdata_s;

  // Next-state logic, access decode and the array write-port mux.
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    rd_s          = 1'b0;
    wr_s          = 1'b0;
    conf_s        = 1'b0;
    arr_we_s      = 1'b0;
    arr_addr_s    = A;
    arr_wdata_s   = D;
    case (state_r)
      CLEAR: begin
        arr_we_s      = 1'b1;
        arr_addr_s    = clr_ptr_r;
        arr_wdata_s   = '0;
        clr_ptr_nxt_s = clr_ptr_r + AW'(1);
        if (clr_ptr_r == AW'(DEPTH - 1)) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      READY: begin
        state_nxt_s = READY;
        // ready_r gates access so the no-sweep variant ignores the first cycle.
        if (ready_r && CEN) begin
          rd_s   = OEN & ~WEN;
          wr_s   = WEN & ~OEN;
          conf_s = WEN & OEN;
        end else begin
          rd_s   = 1'b0;
          wr_s   = 1'b0;
          conf_s = 1'b0;
        end
        arr_we_s = wr_s;
      end
      default: begin
        state_nxt_s = CLEAR;
      end
    endcase
  end

  // Controller state, status flag and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= RST_STATE;
      clr_ptr_r <= '0;
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      rd_cnt_r  <= '0;
      wr_cnt_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_ptr_r <= clr_ptr_nxt_s;
      ready_r   <= (state_nxt_s == READY);
      if (conf_s) begin
        err_r <= 1'b1;
      end
      if (rd_s) begin
        rd_cnt_r <= sat_inc(rd_cnt_r);
      end
      if (wr_s) begin
        wr_cnt_r <= sat_inc(wr_cnt_r);
      end
    end
  end

  // A write presented in the same cycle as reset is dropped.
  dmem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s & rst_n),
    .waddr (arr_addr_s),
    .wdata (arr_wdata_s),
    .raddr (A),
    .rdata (arr_rdata_s)
  );

  // Read data is driven only for an honoured read, zero otherwise.
  always_comb begin
    if (rd_s) begin
      Q = arr_rdata_s;
    end else begin
      Q = '0;
    end
  end

  assign ready  = ready_r;
  assign err    = err_r;
  assign rd_cnt = rd_cnt_r;
  assign wr_cnt = wr_cnt_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder with a behavioural model.
module tb_data_mem_responder;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          CEN   = 1'b0;
  logic          WEN   = 1'b0;
  logic          OEN   = 1'b0;
  logic [AW-1:0] A     = '0;
  logic [DW-1:0] D     = '0;
  logic [DW-1:0] Q;
  logic          ready;
  logic          err;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Behavioural model: edges since release, readiness, memory image, counts.
  logic [DW-1:0] mem_m [DEPTH];
  int            rel_edges = 0;
  bit            ready_m   = 1'b0;
  bit            err_m     = 1'b0;
  int            rd_m      = 0;
  int            wr_m      = 0;

  data_mem_responder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .CEN    (CEN),
    .WEN    (WEN),
    .OEN    (OEN),
    .A      (A),
    .D      (D),
    .Q      (Q),
    .ready  (ready),
    .err    (err),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit w, input bit o,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    CEN = c; WEN = w; OEN = o; A = a; D = d;
  endtask

  // Model update: ready comes DEPTH edges after release with the array all zero.
  always @(posedge clk) begin
    if (!rst_n) begin
      rel_edges = 0; ready_m = 1'b0; err_m = 1'b0; rd_m = 0; wr_m = 0;
    end else if (!ready_m) begin
      rel_edges++;
      if (rel_edges == DEPTH) begin
        ready_m = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end
    end else if (CEN) begin
      if (WEN && OEN) err_m = 1'b1;
      else if (WEN) begin
        mem_m[A] = D;
        if (wr_m < 65535) wr_m++;
      end else if (OEN) begin
        if (rd_m < 65535) rd_m++;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic [DW-1:0] exp_q;
    if (check_en) begin
      exp_q = (ready_m && CEN && OEN && !WEN) ? mem_m[A] : '0;
      chk("q", Q, exp_q);
      chk("ready", {31'd0, ready}, {31'd0, ready_m});
      chk("err", {31'd0, err}, {31'd0, err_m});
      chk("rd_cnt", {16'd0, rd_cnt}, 32'(rd_m));
      chk("wr_cnt", {16'd0, wr_cnt}, 32'(wr_m));
    end
  end

  // Count edges until ready rises; optionally attempt a write at a CLEAR cycle.
  task automatic wait_ready(output int edges, input int write_at);
    edges = 0;
    while (ready !== 1'b1 && edges < 300) begin
      tick();
      edges++;
      if (edges == write_at) drive(1'b1, 1'b1, 1'b0, 7'd9, 32'hCAFEF00D);
      else drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int edges;
    int need;
    // Reset held for two edges.
    tick();
    check_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    chk("rst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready(edges, 10);
    chk("ready_latency", 32'(edges), 32'd128);
    chk("clear_write_ignored", {16'd0, wr_cnt}, 32'd0);

    // Write then read back the same word in the next cycle.
    tick(); drive(1'b1, 1'b1, 1'b0, 7'd5, 32'hDEADBEEF);
    tick(); drive(1'b1, 1'b0, 1'b1, 7'd5, 32'd0);
    @(negedge clk);
    chk("read_after_write", Q, 32'hDEADBEEF);
    tick(); drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    @(negedge clk);
    chk("wr_cnt_one", {16'd0, wr_cnt}, 32'd1);
    chk("rd_cnt_one", {16'd0, rd_cnt}, 32'd1);

    // Every word is zero after the sweep except the one just written.
    for (int a = 0; a < DEPTH; a++) begin
      tick(); drive(1'b1, 1'b0, 1'b1, AW'(a), 32'd0);
      @(negedge clk);
      chk("sweep_read", Q, (a == 5) ? 32'hDEADBEEF : 32'd0);
    end

    // Conflict: no write, Q low, err sticky.
    tick(); drive(1'b1, 1'b1, 1'b1, 7'd5, 32'd0);
    @(negedge clk);
    chk("conflict_q", Q, 32'd0);
    chk("err_before_edge", {31'd0, err}, 32'd0);
    tick(); drive(1'b1, 1'b0, 1'b1, 7'd5, 32'd0);
    @(negedge clk);
    chk("err_set", {31'd0, err}, 32'd1);
    chk("conflict_no_write", Q, 32'hDEADBEEF);
    tick(); drive(1'b1, 1'b1, 1'b0, 7'd7, 32'h12345678);
    tick(); drive(1'b0, 1'b1, 1'b1, 7'd3, 32'd0);
    @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("cen_low_q", Q, 32'd0);

    // Reset with a write in flight, then reset again mid-sweep.
    tick(); rst_n = 1'b0; drive(1'b1, 1'b1, 1'b0, 7'd5, 32'h11111111);
    tick(); rst_n = 1'b1; drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    repeat (60) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready(edges, 0);
    chk("restart_latency", 32'(edges), 32'd128);
    tick(); drive(1'b1, 1'b0, 1'b1, 7'd5, 32'd0);
    @(negedge clk);
    chk("reswept_word", Q, 32'd0);

    // Fully random traffic, conflicts included.
    for (int i = 0; i < 1500; i++) begin
      tick();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, DEPTH - 1)), $urandom);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    tick();

    // Read-heavy traffic up to 16'hFFFE, then three reads into saturation.
    need = 65534 - rd_m;
    for (int i = 0; i < need; i++) begin
      if (i % 32 == 0) begin
        tick(); drive(1'b1, 1'b1, 1'b0, AW'($urandom_range(0, DEPTH - 1)), $urandom);
      end
      tick(); drive(1'b1, 1'b0, 1'b1, AW'($urandom_range(0, DEPTH - 1)), 32'd0);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    @(negedge clk);
    chk("rd_cnt_fffe", {16'd0, rd_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b1, 1'b0, 1'b1, AW'(i), 32'd0);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    @(negedge clk);
    chk("rd_cnt_sat", {16'd0, rd_cnt}, 32'h0000FFFF);
    tick(); drive(1'b1, 1'b0, 1'b1, 7'd1, 32'd0);
    tick(); drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    @(negedge clk);
    chk("rd_cnt_hold", {16'd0, rd_cnt}, 32'h0000FFFF);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
